mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have these M-stage inputs from the EX/MEM register:
- `RegWriteM`, `MemtoRegM`, `MemWriteM`: 1 bit each.
- `ALUOutM`, `WriteDataM`: 32 bits each.
- `WriteRegM`: 5 bits.
- `LoadTypeM`: 3 bits.
- `SaveTypeM`: 2 bits.
REQ-004 SHALL have these memory-bus outputs:
- `mem_req`: 1 bit.
- `mem_we`: 1 bit.
- `mem_addr`: 32 bits, word-aligned.
- `mem_wdata`: 32 bits.
- `mem_be`: 4 bits, byte enables.
REQ-005 SHALL have memory-bus inputs `mem_rdata` (32 bits) and `mem_ack` (1 bit, one-cycle completion pulse).
REQ-006 SHALL have output `StallM`, 1 bit: freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-007 SHALL have these W-stage outputs (the MEM/WB register):
- `RegWriteW`, `MemtoRegW`: 1 bit each.
- `ALUOutW`, `ReadDataW`: 32 bits each.
- `WriteRegW`: 5 bits.

Function
REQ-008 SHALL use these LoadType encodings: 0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; 5-7 are treated as LW.
REQ-009 SHALL use these SaveType encodings: 0=SW, 1=SH, 2=SB; 3 is treated as SW.
REQ-010 SHALL define memop = `MemtoRegM | MemWriteM`; if both are high, the operation is a store.
REQ-011 SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-012 In IDLE, SHALL go to WAIT when memop=1, otherwise stay in IDLE.
REQ-013 In WAIT, SHALL go to DONE on `mem_ack`, otherwise stay in WAIT.
REQ-014 In DONE, SHALL go to IDLE unconditionally.
REQ-015 SHALL drive `StallM` = memop & (state != DONE), combinationally.
REQ-016 SHALL register the bus outputs and assert `mem_req` only in WAIT; address, data, enables and `we` stay stable throughout WAIT.
REQ-017 SHALL drive `mem_addr` = {`ALUOutM`[31:2], 2'b00}.
REQ-018 SHALL form store lanes as follows:
- SW: `mem_be`=1111, data unchanged.
- SH: `mem_be`=0011<<(2*`ALUOutM`[1]), halfword replicated in both halves.
- SB: `mem_be`=0001<<`ALUOutM`[1:0], byte replicated in all four lanes.
REQ-019 SHALL drive `mem_be`=1111 for loads.
REQ-020 SHALL ignore misaligned low address bits: bit 0 for halfword accesses, bits 1:0 for word accesses.
REQ-021 On `mem_ack` in WAIT, SHALL latch the lane-extracted load data:
- Halfword selected by `ALUOutM`[1]; byte selected by `ALUOutM`[1:0].
- LH and LB sign-extend; LHU and LBU zero-extend.
REQ-022 SHALL ignore `mem_ack` outside WAIT.
REQ-023 When `StallM`=0, SHALL update the W register on each rising edge:
- `RegWriteW`, `MemtoRegW`, `ALUOutW` and `WriteRegW` from the M inputs.
- `ReadDataW` from the latched load data.
REQ-024 When `StallM`=1, SHALL load the W register with a bubble: `RegWriteW`=0, `MemtoRegW`=0, other fields held.
REQ-025 SHALL give these latencies:
- Non-memop: 1 cycle through M.
- Memop: 2 + N cycles, where N ≥ 1 is the number of WAIT cycles up to and including the ack cycle.
- Minimum memop: 3 cycles.
REQ-026 SHALL leave `ReadDataW` unchanged for stores; `MemtoRegW` is 0 in that case.

Reset
REQ-027 On `rst_n`=0, SHALL asynchronously force:
- state=IDLE.
- `mem_req`=0, `mem_we`=0, `mem_be`=0000, `mem_addr`=0, `mem_wdata`=0.
- All W outputs and the latched load data = 0.
REQ-028 On reset during WAIT, SHALL drop `mem_req` immediately and discard any later ack.
REQ-029 SHALL hold `StallM` low throughout reset.

Structure
REQ-030 SHALL take the LoadType and SaveType encodings and the FSM state encoding from the shared package (`mips_pkg`).
REQ-031 SHALL put byte-lane formatting in a combinational sub-module `mem_lane` (store replicate + enables; load extract + extend); the FSM and registers stay in `mem_stage`.

Verification
REQ-032 The bench SHALL cover ALU op bypass:
- Stimulus: `RegWriteM`=1, `ALUOutM`=0x1234, `WriteRegM`=5, no memop.
- Required: `StallM`=0; next edge `ALUOutW`=0x1234, `RegWriteW`=1; `mem_req` never asserted.
REQ-033 The bench SHALL cover LB with sign extension:
- Stimulus: addr=0x103, `mem_rdata`=0x80FF_FF7F, ack on the first WAIT cycle.
- Required: `StallM` high 2 cycles; `ReadDataW`=0xFFFF_FF80; `mem_addr`=0x100.
REQ-034 The bench SHALL cover SH to the upper half:
- Stimulus: addr=0x202, `WriteDataM`=0xAAAA_BEEF.
- Required: `mem_be`=1100, `mem_wdata`=0xBEEF_BEEF, `mem_we`=1.
REQ-035 The bench SHALL cover a wait-stated load:
- Stimulus: LW with ack arriving 4 cycles after `mem_req` rises.
- Required: `mem_req` held 5 cycles with stable addr; `StallM` high 6 cycles; W register shows bubbles, then valid data.
REQ-036 The bench SHALL cover reset mid-WAIT:
- Stimulus: assert `rst_n`=0 two cycles into WAIT; ack arrives after release.
- Required: `mem_req`=0 immediately; state IDLE; ack ignored; W outputs = 0.
REQ-037 The bench SHALL cover LHU on an odd halfword:
- Stimulus: addr=0x11 with `mem_rdata`=0x8001_7FFF.
- Required: lower halfword used (bit 0 ignored); `ReadDataW`=0x0000_7FFF.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for load/store types and the memory-stage FSM.
package mips_pkg;
  typedef enum logic [2:0] {LT_LW = 3'd0, LT_LH = 3'd1, LT_LHU = 3'd2, LT_LB = 3'd3, LT_LBU = 3'd4} loadType_e;
  typedef enum logic [1:0] {ST_SW = 2'd0, ST_SH = 2'd1, ST_SB = 2'd2} saveType_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} memState_e;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: word-addressed data-memory bus with byte enables and a one-cycle ack.
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_lane.sv
// mem_lane: byte-lane formatting; store replication and enables, load extraction and extension.
module mem_lane
  import mips_pkg::*;
(
  input  logic        isStore,
  input  logic [1:0]  addrLow,
  input  logic [2:0]  loadType,
  input  logic [1:0]  saveType,
  input  logic [31:0] storeData,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] loadData
);
  logic [15:0] half;
  logic [7:0]  byteSel;
  always_comb begin
    half     = addrLow[1] ? rdata[31:16] : rdata[15:0];
    byteSel  = rdata[{addrLow, 3'b000} +: 8];
    wdata    = saveType == ST_SH ? {2{storeData[15:0]}} :
               saveType == ST_SB ? {4{storeData[7:0]}} : storeData;
    be       = !isStore          ? 4'b1111 :
               saveType == ST_SH ? (addrLow[1] ? 4'b1100 : 4'b0011) :
               saveType == ST_SB ? 4'b0001 << addrLow : 4'b1111;
    loadData = loadType == LT_LH  ? {{16{half[15]}}, half} :
               loadType == LT_LHU ? {16'h0, half} :
               loadType == LT_LB  ? {{24{byteSel[7]}}, byteSel} :
               loadType == LT_LBU ? {24'h0, byteSel} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: M stage with a blocking memory handshake and the MEM/WB register.
module mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  SaveTypeM,
  mem_stage_if.master bus,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ALUOutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  WriteRegW
);
  memState_e   state, nextState;
  logic        memop;
  logic [31:0] laneWdata, laneLoad, loadData;
  logic [3:0]  laneBe;
  mem_lane u_lane (
    .isStore(MemWriteM), .addrLow(ALUOutM[1:0]), .loadType(LoadTypeM), .saveType(SaveTypeM),
    .storeData(WriteDataM), .rdata(bus.mem_rdata), .wdata(laneWdata), .be(laneBe), .loadData(laneLoad)
  );
  always_comb begin
    memop     = MemtoRegM | MemWriteM;
    nextState = state == S_IDLE ? (memop ? S_WAIT : S_IDLE) :
                state == S_WAIT ? (bus.mem_ack ? S_DONE : S_WAIT) : S_IDLE;
    StallM    = rst_n & memop & (state != S_DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nextState;
  // Bus fields are captured once on entry to WAIT so they stay stable until the ack.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
    end else begin
      bus.mem_req <= nextState == S_WAIT;
      if (state == S_IDLE && memop) begin
        bus.mem_we    <= MemWriteM;
        bus.mem_be    <= laneBe;
        bus.mem_addr  <= {ALUOutM[31:2], 2'b00};
        bus.mem_wdata <= laneWdata;
      end
    end
  // Only loads refresh the latch, so stores leave ReadDataW untouched.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) loadData <= 32'h0;
    else if (state == S_WAIT && bus.mem_ack && MemtoRegM && !MemWriteM) loadData <= laneLoad;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ALUOutW   <= 32'h0;
      ReadDataW <= 32'h0;
      WriteRegW <= 5'd0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      ALUOutW   <= ALUOutM;
      ReadDataW <= loadData;
      WriteRegW <= WriteRegM;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random transactions against an arithmetic reference model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic [2:0]  LoadTypeM;
  logic [1:0]  SaveTypeM;
  logic        StallM, RegWriteW, MemtoRegW;
  logic [31:0] ALUOutW, ReadDataW;
  logic [4:0]  WriteRegW;
  logic [31:0] expRd;
  int          vectors = 0;
  int          errors = 0;
  mem_stage_if bus();
  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .LoadTypeM(LoadTypeM),
    .SaveTypeM(SaveTypeM), .bus(bus), .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] expLoad(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] rd);
    int unsigned b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (lt)
      3'd1: return h >= 32'h8000 ? h - 32'h10000 : h;
      3'd2: return h;
      3'd3: return b >= 32'h80 ? b - 32'h100 : b;
      3'd4: return b;
      default: return rd;
    endcase
  endfunction
  function automatic logic [3:0] expBe(input logic store, input logic [1:0] st, input logic [31:0] a);
    if (!store) return 4'hF;
    if (st == 2'd1) return 4'(3 << (2 * a[1]));
    if (st == 2'd2) return 4'(1 << a[1:0]);
    return 4'hF;
  endfunction
  function automatic logic [31:0] expWdata(input logic [1:0] st, input logic [31:0] wd);
    if (st == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    if (st == 2'd2) return (wd & 32'hFF) * 32'h0101_0101;
    return wd;
  endfunction
  task automatic runOp(input logic rw, mtr, mw, input logic [31:0] alu, wd, input logic [4:0] wr,
                       input logic [2:0] lt, input logic [1:0] st, input int delay, input logic [31:0] rd);
    int stalls, reqs, cyc;
    logic memop;
    memop = mtr | mw;
    RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw; ALUOutM = alu; WriteDataM = wd;
    WriteRegM = wr; LoadTypeM = lt; SaveTypeM = st; bus.mem_ack = 1'b0;
    #1;
    stalls = 0; reqs = 0; cyc = 0;
    while (StallM && cyc < 50) begin
      stalls++;
      if (cyc > 0) begin
        chk("bubble_rw", RegWriteW, 0);
        chk("bubble_mtr", MemtoRegW, 0);
        chk("req_wait", bus.mem_req, 1);
      end else chk("req_idle", bus.mem_req, 0);
      if (bus.mem_req) begin
        reqs++;
        chk("addr", bus.mem_addr, {alu[31:2], 2'b00});
        chk("be", bus.mem_be, expBe(mw, st, alu));
        chk("we", bus.mem_we, mw);
        if (mw) chk("wdata", bus.mem_wdata, expWdata(st, wd));
        if (reqs == delay + 1) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rd;
        end
      end
      @(posedge clk); @(negedge clk);
      bus.mem_ack = 1'b0;
      cyc++;
    end
    chk("req_done", bus.mem_req, 0);
    chk("stall_cycles", stalls, memop ? delay + 2 : 0);
    chk("req_cycles", reqs, memop ? delay + 1 : 0);
    if (mtr && !mw) expRd = expLoad(lt, alu, rd);
    @(posedge clk); @(negedge clk);
    chk("RegWriteW", RegWriteW, rw);
    chk("MemtoRegW", MemtoRegW, mtr);
    chk("ALUOutW", ALUOutW, alu);
    chk("WriteRegW", WriteRegW, wr);
    chk("ReadDataW", ReadDataW, expRd);
  endtask
  initial begin
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h55; WriteDataM = 32'h0;
    WriteRegM = 5'd1; LoadTypeM = 3'd0; SaveTypeM = 2'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    expRd = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", StallM, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_be", bus.mem_be, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rw", RegWriteW, 0);
    chk("rst_alu", ALUOutW, 0);
    chk("rst_rd", ReadDataW, 0);
    MemtoRegM = 1'b0; RegWriteM = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    runOp(1, 0, 0, 32'h1234, 0, 5, 0, 0, 0, 0);
    runOp(1, 1, 0, 32'h103, 0, 9, 3'd3, 0, 0, 32'h80FF_FF7F);
    chk("lb_addr", bus.mem_addr, 32'h100);
    chk("lb_data", ReadDataW, 32'hFFFF_FF80);
    runOp(0, 0, 1, 32'h202, 32'hAAAA_BEEF, 0, 0, 2'd1, 1, 0);
    chk("sh_be", bus.mem_be, 4'b1100);
    chk("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    chk("sh_we", bus.mem_we, 1);
    chk("sh_keep_rd", ReadDataW, 32'hFFFF_FF80);
    runOp(1, 1, 0, 32'h3007, 0, 12, 3'd0, 0, 4, 32'hCAFE_F00D);
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h400; LoadTypeM = 3'd0;
    @(posedge clk); @(negedge clk);
    chk("rw_req1", bus.mem_req, 1);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_req_drop", bus.mem_req, 0);
    chk("rw_stall", StallM, 0);
    chk("rw_W_rw", RegWriteW, 0);
    chk("rw_W_alu", ALUOutW, 0);
    chk("rw_W_rd", ReadDataW, 0);
    RegWriteM = 1'b0; MemtoRegM = 1'b0; ALUOutM = 32'h0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("rw_ack_req", bus.mem_req, 0);
    chk("rw_ack_rd", ReadDataW, 0);
    chk("rw_ack_stall", StallM, 0);
    expRd = 32'h0;
    runOp(1, 1, 0, 32'h11, 0, 3, 3'd2, 0, 0, 32'h8001_7FFF);
    chk("lhu_data", ReadDataW, 32'h0000_7FFF);
    for (int i = 0; i < 40; i++)
      runOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
